// File: rtl/set_cache_miss_sequencer.sv
// -----------------------------------------------------------------------------
// set_cache_miss_sequencer
//
// Purpose:
//   Sits upstream of a set-associative replacement policy controller
//   (PLRU/SRRIP). It consumes tag-lookup results and does four things:
//   - drives the policy hit/miss strobes and the block address;
//   - picks a victim (the lowest invalid way first, otherwise the policy
//     victim);
//   - runs the writeback and fill handshakes;
//   - commits the per-block valid/dirty state.
//   Block addresses are {way, group}: the way index is in the MSBs and the
//   group (set index) is in the LSBs.
//
// Ports:
//   clock_i         rising-edge clock
//   reset_i         synchronous, active-high reset
//   lookup_valid_i  lookup result valid (accepted only while lookup_ready_o)
//   lookup_hit_i    1 = hit, 0 = miss
//   lookup_we_i     access is a write (marks block dirty)
//   lookup_group_i  group of the access
//   lookup_way_i    hit way (ignored on miss)
//   lookup_tag_i    tag of the access, latched for the fill
//   lookup_ready_o  high only while idle
//   pol_hit_o       one-cycle policy update strobe
//   pol_miss_o      one-cycle policy miss strobe
//   pol_addr_o      {way,group} presented to the policy controller
//   pol_done_i      policy victim valid
//   pol_addr_i      policy victim {way,group}; only the way field is used
//   wb_req_o        writeback request, held until wb_ack_i
//   wb_addr_o       address of the block being written back
//   wb_ack_i        writeback complete
//   fill_req_o      fill request, held until fill_ack_i
//   fill_addr_o     address of the block being filled
//   fill_tag_o      latched miss tag
//   fill_ack_i      fill complete
//   done_o          one-cycle pulse when a miss has been serviced
// -----------------------------------------------------------------------------
module set_cache_miss_sequencer #(
  parameter  int CACHE_BLOCK_CAPACITY = 128,
  parameter  int CACHE_SET_SIZE       = 4,
  parameter  int BW_TAG               = 20,
  localparam int BW_CAP               = $clog2(CACHE_BLOCK_CAPACITY),
  localparam int BW_SET               = $clog2(CACHE_SET_SIZE),
  localparam int BW_GRP               = BW_CAP - BW_SET
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              lookup_valid_i,
  input  logic              lookup_hit_i,
  input  logic              lookup_we_i,
  input  logic [BW_GRP-1:0] lookup_group_i,
  input  logic [BW_SET-1:0] lookup_way_i,
  input  logic [BW_TAG-1:0] lookup_tag_i,
  output logic              lookup_ready_o,
  output logic              pol_hit_o,
  output logic              pol_miss_o,
  output logic [BW_CAP-1:0] pol_addr_o,
  input  logic              pol_done_i,
  input  logic [BW_CAP-1:0] pol_addr_i,
  output logic              wb_req_o,
  output logic [BW_CAP-1:0] wb_addr_o,
  input  logic              wb_ack_i,
  output logic              fill_req_o,
  output logic [BW_CAP-1:0] fill_addr_o,
  output logic [BW_TAG-1:0] fill_tag_o,
  input  logic              fill_ack_i,
  output logic              done_o
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_VICTIM    = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_FILL      = 3'd3,
    ST_COMMIT    = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Per-block state, indexed by {way, group}.
  logic [CACHE_BLOCK_CAPACITY-1:0] valid_q;
  logic [CACHE_BLOCK_CAPACITY-1:0] dirty_q;

  // Miss context latched when the miss is accepted.
  logic [BW_GRP-1:0] grp_q,    grp_d;
  logic [BW_TAG-1:0] tag_q,    tag_d;
  logic              we_q,     we_d;
  logic [BW_SET-1:0] victim_q, victim_d;

  // Registered outputs.
  logic              ready_q,     ready_d;
  logic              pol_hit_q,   pol_hit_d;
  logic              pol_miss_q,  pol_miss_d;
  logic [BW_CAP-1:0] pol_addr_q,  pol_addr_d;
  logic              wb_req_q,    wb_req_d;
  logic [BW_CAP-1:0] wb_addr_q,   wb_addr_d;
  logic              fill_req_q,  fill_req_d;
  logic [BW_CAP-1:0] fill_addr_q, fill_addr_d;
  logic              done_q,      done_d;

  // Array update controls.
  logic              set_dirty_s;
  logic [BW_CAP-1:0] dirty_addr_s;
  logic              commit_s;
  logic              victim_go_s;

  // Invalid-way search within the latched group.
  logic              any_inv_s;
  logic [BW_SET-1:0] inv_way_s;

  // Only the way field of the policy victim is used; the latched group wins.
  logic unused_pol_grp_s;
  assign unused_pol_grp_s = ^pol_addr_i[BW_GRP-1:0];

  // Find the lowest-index invalid way of the latched group. Scan from the top so the lowest index is written last.
  always_comb begin
    any_inv_s = 1'b0;
    inv_way_s = {BW_SET{1'b0}};
    for (int w = CACHE_SET_SIZE - 1; w >= 0; w--) begin
      if (!valid_q[{w[BW_SET-1:0], grp_q}]) begin
        any_inv_s = 1'b1;
        inv_way_s = w[BW_SET-1:0];
      end else begin
        any_inv_s = any_inv_s;
      end
    end
  end

  // Next-state and next-output logic for the miss sequencer FSM.
  always_comb begin
    state_d      = state_q;
    grp_d        = grp_q;
    tag_d        = tag_q;
    we_d         = we_q;
    victim_d     = victim_q;
    pol_hit_d    = 1'b0;
    pol_miss_d   = 1'b0;
    pol_addr_d   = pol_addr_q;
    wb_req_d     = 1'b0;
    wb_addr_d    = wb_addr_q;
    fill_req_d   = 1'b0;
    fill_addr_d  = fill_addr_q;
    done_d       = 1'b0;
    set_dirty_s  = 1'b0;
    dirty_addr_s = {lookup_way_i, lookup_group_i};
    commit_s     = 1'b0;
    victim_go_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (lookup_valid_i) begin
          if (lookup_hit_i) begin
            pol_hit_d   = 1'b1;
            pol_addr_d  = {lookup_way_i, lookup_group_i};
            set_dirty_s = lookup_we_i;
          end else begin
            grp_d      = lookup_group_i;
            tag_d      = lookup_tag_i;
            we_d       = lookup_we_i;
            pol_miss_d = 1'b1;
            pol_addr_d = {{BW_SET{1'b0}}, lookup_group_i};
            state_d    = ST_VICTIM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_VICTIM: begin
        // An empty way always wins over the policy, even if pol_done_i is also high.
        if (any_inv_s) begin
          victim_d    = inv_way_s;
          victim_go_s = 1'b1;
        end else if (pol_done_i) begin
          victim_d    = pol_addr_i[BW_CAP-1 -: BW_SET];
          victim_go_s = 1'b1;
        end else begin
          victim_go_s = 1'b0;
        end

        if (victim_go_s) begin
          if (valid_q[{victim_d, grp_q}] && dirty_q[{victim_d, grp_q}]) begin
            state_d   = ST_WRITEBACK;
            wb_req_d  = 1'b1;
            wb_addr_d = {victim_d, grp_q};
          end else begin
            state_d     = ST_FILL;
            fill_req_d  = 1'b1;
            fill_addr_d = {victim_d, grp_q};
          end
        end else begin
          state_d = ST_VICTIM;
        end
      end

      ST_WRITEBACK: begin
        if (wb_ack_i && wb_req_q) begin
          state_d     = ST_FILL;
          fill_req_d  = 1'b1;
          fill_addr_d = {victim_q, grp_q};
        end else begin
          wb_req_d = 1'b1;
        end
      end

      ST_FILL: begin
        if (fill_ack_i && fill_req_q) begin
          // Entering COMMIT: the new line is reported as a hit so the policy makes it MRU.
          state_d    = ST_COMMIT;
          pol_hit_d  = 1'b1;
          pol_addr_d = {victim_q, grp_q};
          done_d     = 1'b1;
        end else begin
          fill_req_d = 1'b1;
        end
      end

      ST_COMMIT: begin
        commit_s = 1'b1;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // FSM state, latched miss context and registered outputs.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      grp_q       <= {BW_GRP{1'b0}};
      tag_q       <= {BW_TAG{1'b0}};
      we_q        <= 1'b0;
      victim_q    <= {BW_SET{1'b0}};
      ready_q     <= 1'b1;
      pol_hit_q   <= 1'b0;
      pol_miss_q  <= 1'b0;
      pol_addr_q  <= {BW_CAP{1'b0}};
      wb_req_q    <= 1'b0;
      wb_addr_q   <= {BW_CAP{1'b0}};
      fill_req_q  <= 1'b0;
      fill_addr_q <= {BW_CAP{1'b0}};
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      tag_q       <= tag_d;
      we_q        <= we_d;
      victim_q    <= victim_d;
      ready_q     <= ready_d;
      pol_hit_q   <= pol_hit_d;
      pol_miss_q  <= pol_miss_d;
      pol_addr_q  <= pol_addr_d;
      wb_req_q    <= wb_req_d;
      wb_addr_q   <= wb_addr_d;
      fill_req_q  <= fill_req_d;
      fill_addr_q <= fill_addr_d;
      done_q      <= done_d;
    end
  end

  // Valid/dirty arrays: write hits mark dirty, commits install the filled line.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid_q <= {CACHE_BLOCK_CAPACITY{1'b0}};
      dirty_q <= {CACHE_BLOCK_CAPACITY{1'b0}};
    end else if (set_dirty_s) begin
      dirty_q[dirty_addr_s] <= 1'b1;
    end else if (commit_s) begin
      valid_q[{victim_q, grp_q}] <= 1'b1;
      dirty_q[{victim_q, grp_q}] <= we_q;
    end else begin
      valid_q <= valid_q;
      dirty_q <= dirty_q;
    end
  end

  assign lookup_ready_o = ready_q;
  assign pol_hit_o      = pol_hit_q;
  assign pol_miss_o     = pol_miss_q;
  assign pol_addr_o     = pol_addr_q;
  assign wb_req_o       = wb_req_q;
  assign wb_addr_o      = wb_addr_q;
  assign fill_req_o     = fill_req_q;
  assign fill_addr_o    = fill_addr_q;
  assign fill_tag_o     = tag_q;
  assign done_o         = done_q;

endmodule
